// File: rtl/vscale_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// vscale_wb_arbiter_pkg
// Shared constants for the register-file write-port controller.
//   XPR_LEN         : integer register width
//   REG_ADDR_WIDTH  : register address width
//   NUM_REGS        : number of architectural registers (scoreboard width)
//   wb_src_e        : writeback requester encoding (ALU = 0, load = 1)
//   reg_onehot()    : one-hot decode of a register address
// ---------------------------------------------------------------------------
package vscale_wb_arbiter_pkg;

    localparam int XPR_LEN        = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LD  = 1'b1
    } wb_src_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_WIDTH-1:0] addr);
        logic [NUM_REGS-1:0] one;
        one = {{(NUM_REGS-1){1'b0}}, 1'b1};
        return one << addr;
    endfunction

endpackage

// File: rtl/vscale_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// vscale_wb_arbiter_if
// Bundles the two writeback request channels, the load-issue notification,
// the register-file write port and the exported busy scoreboard.
//   master : pipeline side (drives requests, sees readys / rf write / busy)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface vscale_wb_arbiter_if;
    import vscale_wb_arbiter_pkg::*;

    logic                      alu_wb_valid;
    logic                      alu_wb_ready;
    logic [REG_ADDR_WIDTH-1:0] alu_wb_addr;
    logic [XPR_LEN-1:0]        alu_wb_data;

    logic                      ld_wb_valid;
    logic                      ld_wb_ready;
    logic [REG_ADDR_WIDTH-1:0] ld_wb_addr;
    logic [XPR_LEN-1:0]        ld_wb_data;

    logic                      ld_issue;
    logic [REG_ADDR_WIDTH-1:0] ld_issue_addr;

    logic                      rf_wen;
    logic [REG_ADDR_WIDTH-1:0] rf_wa;
    logic [XPR_LEN-1:0]        rf_wd;

    logic [NUM_REGS-1:0]       busy;

    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data,
        output ld_wb_valid, ld_wb_addr, ld_wb_data,
        output ld_issue, ld_issue_addr,
        input  alu_wb_ready, ld_wb_ready,
        input  rf_wen, rf_wa, rf_wd, busy
    );

    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data,
        input  ld_wb_valid, ld_wb_addr, ld_wb_data,
        input  ld_issue, ld_issue_addr,
        output alu_wb_ready, ld_wb_ready,
        output rf_wen, rf_wa, rf_wd, busy
    );

endinterface

// File: rtl/vscale_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// vscale_wb_scoreboard
// Pending-load scoreboard: one bit per register, set when a load issues to
// it and cleared when that load's data is written back.
//   clk, reset_n    : clock, synchronous active-low reset
//   set_i/set_addr_i: load issued to set_addr_i
//   clr_i/clr_addr_i: load writeback granted to clr_addr_i
//   busy_o          : scoreboard vector, bit n = load to xn outstanding
// ---------------------------------------------------------------------------
module vscale_wb_scoreboard
    import vscale_wb_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      set_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                      clr_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
    output logic [NUM_REGS-1:0]       busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d = busy_d & ~reg_onehot(clr_addr_i);
        end
        // Applied after the clear so a same-cycle issue to the register being
        // written back leaves it pending for the new load.
        if (set_i) begin
            busy_d = busy_d | reg_onehot(set_addr_i);
        end
        // x0 is hardwired zero; nothing ever waits on it.
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/vscale_wb_arbiter.sv
// ---------------------------------------------------------------------------
// vscale_wb_arbiter
// Shares the register file's single write port between the ALU/CSR
// writeback and the load-return path. Round-robin on conflict, with ALU
// writes held off while an older load to the same register is pending.
//   clk     : clock
//   reset_n : synchronous active-low reset
//   wb      : request channels, load-issue, rf write port, busy (slave)
// Grant-to-write latency is one cycle; readys never depend on rf_* state.
// ---------------------------------------------------------------------------
module vscale_wb_arbiter
    import vscale_wb_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    vscale_wb_arbiter_if.slave wb
);

    logic [NUM_REGS-1:0]       busy;
    logic                      alu_elig;
    logic                      ld_elig;
    logic                      grant_alu;
    logic                      grant_ld;

    wb_src_e                   prio_q, prio_d;
    logic                      rf_wen_q, rf_wen_d;
    logic [REG_ADDR_WIDTH-1:0] rf_wa_q, rf_wa_d;
    logic [XPR_LEN-1:0]        rf_wd_q, rf_wd_d;

    vscale_wb_scoreboard u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_i      (wb.ld_issue),
        .set_addr_i (wb.ld_issue_addr),
        .clr_i      (grant_ld),
        .clr_addr_i (wb.ld_wb_addr),
        .busy_o     (busy)
    );

    always_comb begin
        // Requests seen during reset are dropped, so nothing is eligible.
        ld_elig  = reset_n && wb.ld_wb_valid;
        alu_elig = reset_n && wb.alu_wb_valid &&
                   ((wb.alu_wb_addr == '0) || !busy[wb.alu_wb_addr]);

        grant_ld  = ld_elig  && (!alu_elig || (prio_q == WB_SRC_LD));
        grant_alu = alu_elig && (!ld_elig  || (prio_q == WB_SRC_ALU));

        prio_d   = prio_q;
        rf_wen_d = 1'b0;
        rf_wa_d  = rf_wa_q;
        rf_wd_d  = rf_wd_q;

        // Priority moves to whoever lost (or was idle) after every grant.
        if (grant_ld) begin
            prio_d   = WB_SRC_ALU;
            rf_wen_d = (wb.ld_wb_addr != '0);
            rf_wa_d  = wb.ld_wb_addr;
            rf_wd_d  = wb.ld_wb_data;
        end else if (grant_alu) begin
            prio_d   = WB_SRC_LD;
            rf_wen_d = (wb.alu_wb_addr != '0);
            rf_wa_d  = wb.alu_wb_addr;
            rf_wd_d  = wb.alu_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prio_q   <= WB_SRC_LD;
            rf_wen_q <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            prio_q   <= prio_d;
            rf_wen_q <= rf_wen_d;
            rf_wa_q  <= rf_wa_d;
            rf_wd_q  <= rf_wd_d;
        end
    end

    assign wb.alu_wb_ready = grant_alu;
    assign wb.ld_wb_ready  = grant_ld;
    assign wb.rf_wen       = rf_wen_q;
    assign wb.rf_wa        = rf_wa_q;
    assign wb.rf_wd        = rf_wd_q;
    assign wb.busy         = busy;

endmodule

// File: tb/tb_vscale_wb_arbiter.sv
module tb_vscale_wb_arbiter;
    import vscale_wb_arbiter_pkg::*;

    logic clk;
    logic reset_n;

    vscale_wb_arbiter_if wb();

    vscale_wb_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .wb      (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [XPR_LEN-1:0]        data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [REG_ADDR_WIDTH-1:0] a, input logic [XPR_LEN-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Register-file write monitor: every rf_wen must match the next expected write.
    always @(negedge clk) begin
        if (mon_en && wb.rf_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(wb.rf_wen), 64'd0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("rf_wa", 64'(wb.rf_wa), 64'(w.addr));
                check("rf_wd", 64'(wb.rf_wd), 64'(w.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n          = 1'b0;
        wb.alu_wb_valid  = 1'b0;
        wb.alu_wb_addr   = '0;
        wb.alu_wb_data   = '0;
        wb.ld_wb_valid   = 1'b0;
        wb.ld_wb_addr    = '0;
        wb.ld_wb_data    = '0;
        wb.ld_issue      = 1'b0;
        wb.ld_issue_addr = '0;
        repeat (2) tick();
        check("rst_rf_wen", 64'(wb.rf_wen), 64'd0);
        check("rst_busy", 64'(wb.busy), 64'd0);
        mon_en  = 1'b1;
        reset_n = 1'b1;
        tick();

        // Load write to x1 moves priority to the ALU before the reset test.
        wb.ld_wb_valid = 1'b1; wb.ld_wb_addr = 5'd1; wb.ld_wb_data = 32'h11;
        push_exp(5'd1, 32'h11);
        @(negedge clk);
        check("pre_ld_ready", 64'(wb.ld_wb_ready), 64'd1);
        tick();
        wb.ld_wb_valid = 1'b0;
        wb.ld_issue = 1'b1; wb.ld_issue_addr = 5'd20;
        tick();
        wb.ld_issue = 1'b0;
        check("busy20_set", 64'(wb.busy[20]), 64'd1);

        // Reset mid-transfer.
        wb.ld_wb_valid  = 1'b1; wb.ld_wb_addr  = 5'd7; wb.ld_wb_data  = 32'h77;
        wb.alu_wb_valid = 1'b1; wb.alu_wb_addr = 5'd2; wb.alu_wb_data = 32'h22;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_ld_ready", 64'(wb.ld_wb_ready), 64'd0);
        check("rst_alu_ready", 64'(wb.alu_wb_ready), 64'd0);
        tick();
        wb.ld_wb_valid = 1'b0; wb.alu_wb_valid = 1'b0;
        check("rst2_rf_wen", 64'(wb.rf_wen), 64'd0);
        check("rst2_rf_wa", 64'(wb.rf_wa), 64'd0);
        check("rst2_rf_wd", 64'(wb.rf_wd), 64'd0);
        check("rst2_busy", 64'(wb.busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Sustained contention, first conflict after reset goes to the load.
        wb.ld_wb_valid  = 1'b1; wb.ld_wb_addr  = 5'd4; wb.ld_wb_data  = 32'h44;
        wb.alu_wb_valid = 1'b1; wb.alu_wb_addr = 5'd3; wb.alu_wb_data = 32'h33;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_ld_ready", 64'(wb.ld_wb_ready), 64'((i % 2) == 0));
            check("rr_alu_ready", 64'(wb.alu_wb_ready), 64'((i % 2) == 1));
            if ((i % 2) == 0) push_exp(5'd4, 32'h44);
            else              push_exp(5'd3, 32'h33);
            tick();
        end
        wb.ld_wb_valid = 1'b0; wb.alu_wb_valid = 1'b0;
        tick();

        // Single ALU write, then output register holds with rf_wen low.
        wb.alu_wb_valid = 1'b1; wb.alu_wb_addr = 5'd5; wb.alu_wb_data = 32'hDEADBEEF;
        push_exp(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("alu_ready", 64'(wb.alu_wb_ready), 64'd1);
        tick();
        wb.alu_wb_valid = 1'b0;
        check("alu_wen", 64'(wb.rf_wen), 64'd1);
        tick();
        check("hold_wen", 64'(wb.rf_wen), 64'd0);
        check("hold_wa", 64'(wb.rf_wa), 64'd5);
        check("hold_wd", 64'(wb.rf_wd), 64'hDEADBEEF);

        // WAW ordering on x9.
        wb.ld_issue = 1'b1; wb.ld_issue_addr = 5'd9;
        tick();
        wb.ld_issue = 1'b0;
        check("busy9_set", 64'(wb.busy[9]), 64'd1);
        wb.alu_wb_valid = 1'b1; wb.alu_wb_addr = 5'd9; wb.alu_wb_data = 32'h99;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("waw_alu_blocked", 64'(wb.alu_wb_ready), 64'd0);
            tick();
        end
        wb.ld_wb_valid = 1'b1; wb.ld_wb_addr = 5'd9; wb.ld_wb_data = 32'h900;
        push_exp(5'd9, 32'h900);
        push_exp(5'd9, 32'h99);
        @(negedge clk);
        check("waw_ld_ready", 64'(wb.ld_wb_ready), 64'd1);
        check("waw_alu_still_blocked", 64'(wb.alu_wb_ready), 64'd0);
        tick();
        wb.ld_wb_valid = 1'b0;
        @(negedge clk);
        check("waw_busy9_clr", 64'(wb.busy[9]), 64'd0);
        check("waw_alu_ready", 64'(wb.alu_wb_ready), 64'd1);
        tick();
        wb.alu_wb_valid = 1'b0;
        tick();

        // Simultaneous set/clear on x12.
        wb.ld_issue = 1'b1; wb.ld_issue_addr = 5'd12;
        tick();
        wb.ld_wb_valid = 1'b1; wb.ld_wb_addr = 5'd12; wb.ld_wb_data = 32'hC0C0;
        push_exp(5'd12, 32'hC0C0);
        @(negedge clk);
        check("sc_ld_ready", 64'(wb.ld_wb_ready), 64'd1);
        tick();
        wb.ld_wb_valid = 1'b0; wb.ld_issue = 1'b0;
        check("sc_busy12", 64'(wb.busy[12]), 64'd1);
        wb.ld_wb_valid = 1'b1; wb.ld_wb_data = 32'hC1C1;
        push_exp(5'd12, 32'hC1C1);
        tick();
        wb.ld_wb_valid = 1'b0;
        check("sc_busy12_clr", 64'(wb.busy[12]), 64'd0);

        // x0: handshake completes without a register-file write; busy[0] stays 0.
        wb.alu_wb_valid = 1'b1; wb.alu_wb_addr = 5'd0; wb.alu_wb_data = 32'h1;
        @(negedge clk);
        check("x0_alu_ready", 64'(wb.alu_wb_ready), 64'd1);
        tick();
        wb.alu_wb_valid = 1'b0;
        check("x0_wen", 64'(wb.rf_wen), 64'd0);
        wb.ld_issue = 1'b1; wb.ld_issue_addr = 5'd0;
        tick();
        wb.ld_issue = 1'b0;
        check("x0_busy0", 64'(wb.busy[0]), 64'd0);

        repeat (3) tick();
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
